// File: rtl/uart_rx_tx.sv
`timescale 1ns/100ps
// uart_rx_tx: 8N1 UART board-top block.
//   Receiver latches each valid byte and shows its low 6 bits on the LEDs.
//   Transmitter sends "TEST\r\n" once per push-button press.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   uart_rx - serial in, idle high, asynchronous
//   uart_tx - serial out, idle high
//   led     - low 6 bits of last valid received byte
//   btn     - push button, active-low, asynchronous
// Optional macro UART_LED_ACTIVE_LOW_EN: drive led inverted (active-low
// LEDs), reset value 6'b111111; otherwise led is true, reset 6'b000000.
module uart_rx_tx #(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [5:0] led,
    input  logic       btn
);
    localparam int CW = $clog2(DELAY_FRAMES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);

`ifdef UART_LED_ACTIVE_LOW_EN
    localparam logic [5:0] LED_RST = 6'b111111;
`else
    localparam logic [5:0] LED_RST = 6'b000000;
`endif

    typedef enum logic [2:0] {
        RX_IDLE, RX_START_CHK, RX_DATA, RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_SEND, TX_WAIT_REL
    } tx_state_t;

    function automatic logic [7:0] msg_byte(input logic [2:0] i);
        case (i)
            3'd0:    msg_byte = 8'h54;
            3'd1:    msg_byte = 8'h45;
            3'd2:    msg_byte = 8'h53;
            3'd3:    msg_byte = 8'h54;
            3'd4:    msg_byte = 8'h0D;
            default: msg_byte = 8'h0A;
        endcase
    endfunction

    // Line level for frame position k: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] k);
        logic [3:0] d;
        d = k - 4'd1;
        if (k == 4'd0)      frame_bit = 1'b0;
        else if (k >= 4'd9) frame_bit = 1'b1;
        else                frame_bit = b[d[2:0]];
    endfunction

    // ---------------- synchronisers ----------------
    logic r_rx_s1, r_rx_s2, r_btn_s1, r_btn_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_btn_s1 <= 1'b1;
            r_btn_s2 <= 1'b1;
        end else begin
            r_rx_s1  <= uart_rx;
            r_rx_s2  <= r_rx_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t       r_rx_state, w_rx_state_nx;
    logic [CW-1:0]   r_rx_cnt,   w_rx_cnt_nx;
    logic [2:0]      r_rx_idx,   w_rx_idx_nx;
    logic [7:0]      r_rx_shift, w_rx_shift_nx;
    logic [5:0]      r_led,      w_led_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_led      <= LED_RST;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_idx   <= w_rx_idx_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_led      <= w_led_nx;
        end
    end

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_idx_nx   = r_rx_idx;
        w_rx_shift_nx = r_rx_shift;
        w_led_nx      = r_led;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_s2) begin
                    w_rx_state_nx = RX_START_CHK;
                    w_rx_cnt_nx   = '0;
                end
            end
            RX_START_CHK: begin
                // Re-check the start bit at its middle to reject short glitches.
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nx = '0;
                    w_rx_idx_nx = '0;
                    w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_idx == 3'd7) w_rx_state_nx = RX_STOP;
                    else                  w_rx_idx_nx   = r_rx_idx + 1'b1;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_WAIT_IDLE;
                    if (r_rx_s2) begin
`ifdef UART_LED_ACTIVE_LOW_EN
                        w_led_nx = ~r_rx_shift[5:0];
`else
                        w_led_nx = r_rx_shift[5:0];
`endif
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                // A line stuck low after a framing error must not start a new frame.
                if (r_rx_s2) w_rx_state_nx = RX_IDLE;
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    assign led = r_led;

    // ---------------- transmitter ----------------
    tx_state_t       r_tx_state, w_tx_state_nx;
    logic [CW-1:0]   r_tx_cnt,   w_tx_cnt_nx;
    logic [3:0]      r_tx_bit,   w_tx_bit_nx;
    logic [2:0]      r_tx_byte,  w_tx_byte_nx;
    logic            r_tx,       w_tx_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_byte  <= w_tx_byte_nx;
            r_tx       <= w_tx_nx;
        end
    end

    // The line level is registered and changes on the same edge the bit
    // counter wraps, so every bit is held exactly DELAY_FRAMES clocks.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_byte_nx  = r_tx_byte;
        w_tx_nx       = r_tx;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_nx = 1'b1;
                if (!r_btn_s2) begin
                    w_tx_state_nx = TX_SEND;
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_byte_nx  = '0;
                    w_tx_nx       = 1'b0;
                end
            end
            TX_SEND: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nx = '0;
                    if (r_tx_bit == 4'd9) begin
                        if (r_tx_byte == 3'd5) begin
                            w_tx_state_nx = TX_WAIT_REL;
                            w_tx_nx       = 1'b1;
                        end else begin
                            w_tx_byte_nx = r_tx_byte + 1'b1;
                            w_tx_bit_nx  = '0;
                            w_tx_nx      = 1'b0;
                        end
                    end else begin
                        w_tx_bit_nx = r_tx_bit + 1'b1;
                        w_tx_nx     = frame_bit(msg_byte(r_tx_byte), r_tx_bit + 4'd1);
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_WAIT_REL: begin
                w_tx_nx = 1'b1;
                if (r_btn_s2) w_tx_state_nx = TX_IDLE;
            end
            default: w_tx_state_nx = TX_IDLE;
        endcase
    end

    assign uart_tx = r_tx;

endmodule

// File: tb/tb_uart_rx_tx.sv
`timescale 1ns/100ps
module tb_uart_rx_tx;
    localparam int DF = 8;
    localparam int BITT = 2 * DF;   // time units per bit

`ifdef UART_LED_ACTIVE_LOW_EN
    localparam logic [5:0] LED_RST = 6'b111111;
`else
    localparam logic [5:0] LED_RST = 6'b000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [5:0] led;
    logic       btn = 1'b1;

    int checks = 0;
    int errors = 0;
    int led_chg = 0;

    logic [7:0] msg [6] = '{8'h54, 8'h45, 8'h53, 8'h54, 8'h0D, 8'h0A};

    uart_rx_tx #(.DELAY_FRAMES(DF)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .led(led), .btn(btn)
    );

    always #1 clk = ~clk;

    always @(led) if (!rst) led_chg++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] exp_led(input logic [7:0] b);
`ifdef UART_LED_ACTIVE_LOW_EN
        return ~b[5:0];
`else
        return b[5:0];
`endif
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        #(BITT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(BITT);
        end
        uart_rx = stop;
        #(BITT);
        uart_rx = 1'b1;
    endtask

    // Decode one byte off uart_tx, sampling on negedges at bit middles.
    task automatic get_tx_byte(output logic [7:0] b, output logic ok);
        int n;
        b = 8'h00;
        ok = 1'b0;
        n = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) return;
        #6;
        if (uart_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            #(BITT);
            b[i] = uart_tx;
        end
        #(BITT);
        ok = (uart_tx === 1'b1);
    endtask

    task automatic check_msg(input string tag);
        logic [7:0] b;
        logic ok;
        for (int i = 0; i < 6; i++) begin
            get_tx_byte(b, ok);
            chk({tag, "_frame"}, {31'd0, ok}, 32'd1);
            chk({tag, "_byte"}, {24'd0, b}, {24'd0, msg[i]});
        end
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
    endtask

    initial begin
        int c0, lows, n;
        logic [7:0] b;
        logic ok;

        // Reset state
        #4;
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_led", {26'd0, led}, {26'd0, LED_RST});
        rst = 1'b0;
        #10;

        // RX basic: 'a'
        c0 = led_chg;
        send_frame(8'h61, 1'b1);
        #40;
        chk("rx_61_led", {26'd0, led}, {26'd0, exp_led(8'h61)});
        chk("rx_61_once", led_chg - c0, 32'd1);

        // Short low glitch on idle line
        c0 = led_chg;
        uart_rx = 1'b0;
        #4;
        uart_rx = 1'b1;
        #200;
        chk("glitch_led", {26'd0, led}, {26'd0, exp_led(8'h61)});
        chk("glitch_nochg", led_chg - c0, 32'd0);

        // Framing error then valid byte
        c0 = led_chg;
        send_frame(8'h12, 1'b0);
        #60;
        chk("frame_err_led", {26'd0, led}, {26'd0, exp_led(8'h61)});
        chk("frame_err_nochg", led_chg - c0, 32'd0);
        send_frame(8'h3F, 1'b1);
        #40;
        chk("rx_3f_led", {26'd0, led}, {26'd0, exp_led(8'h3F)});

        // TX message, button held
        btn = 1'b0;
        check_msg("tx");
        count_low(200, lows);
        chk("tx_norepeat", lows, 32'd0);
        btn = 1'b1;
        #20;
        btn = 1'b0;
        get_tx_byte(b, ok);
        chk("tx_repress_frame", {31'd0, ok}, 32'd1);
        chk("tx_repress_byte", {24'd0, b}, 32'h54);
        btn = 1'b1;
        #1000;

        // Concurrency: receive 0x55 while transmitting
        fork
            send_frame(8'h55, 1'b1);
            begin
                #4 btn = 1'b0;
                check_msg("conc");
            end
        join
        btn = 1'b1;
        #40;
        chk("conc_led", {26'd0, led}, {26'd0, exp_led(8'h55)});
        #200;

        // Reset mid-TX during byte 3
        btn = 1'b0;
        get_tx_byte(b, ok);
        get_tx_byte(b, ok);
        n = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midtx_low_before_rst", {31'd0, uart_tx}, 32'd0);
        #0.5;
        rst = 1'b1;
        #0.2;
        chk("midtx_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("midtx_rst_led", {26'd0, led}, {26'd0, LED_RST});
        btn = 1'b1;
        #3.3;
        rst = 1'b0;
        count_low(200, lows);
        chk("post_rst_idle", lows, 32'd0);
        btn = 1'b0;
        get_tx_byte(b, ok);
        chk("post_rst_frame", {31'd0, ok}, 32'd1);
        chk("post_rst_byte", {24'd0, b}, 32'h54);
        btn = 1'b1;
        #100;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
